// File: rtl/fft_io_sequencer.sv
// fft_io_sequencer: input/output sequencer for the 32-point radix-2 DIT FFT core.
// It loads samples into the shared memory at bit-reversed addresses and launches
// the address generator. Once that finishes, it streams the results out in
// natural order through a 2-entry skid FIFO.
module fft_io_sequencer #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned LOG2N  = 5
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     in_re,
    input  logic [DATA_W-1:0]     in_im,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_re,
    output logic [DATA_W-1:0]     out_im,
    output logic                  mem_own,
    output logic [LOG2N-1:0]      mem_addr,
    output logic [2*DATA_W-1:0]   mem_wdata,
    output logic                  mem_we,
    input  logic [2*DATA_W-1:0]   mem_rdata,
    output logic                  start_fft,
    input  logic                  fft_done,
    output logic                  busy
);

    localparam int unsigned N = 1 << LOG2N;
    localparam logic [LOG2N-1:0] LastIdx = LOG2N'(N - 1);
    localparam logic [LOG2N:0] LastOut = (LOG2N + 1)'(N - 1);

    typedef enum logic [1:0] {StLoad, StStart, StWait, StUnload} state_e;

    state_e                 state_q, state_d;
    logic [LOG2N-1:0]       cnt_q, cnt_d;
    logic [LOG2N:0]         rd_cnt_q, rd_cnt_d;   // MSB set once all reads issued
    logic [LOG2N:0]         out_cnt_q, out_cnt_d;
    logic                   armed_q, armed_d;
    logic                   rdy_q, rdy_d;         // holds in_ready low until first edge
    logic                   inflight_q, inflight_d;
    logic [2*DATA_W-1:0]    fifo_q [2];
    logic [2*DATA_W-1:0]    fifo_d [2];
    logic                   wr_ptr_q, wr_ptr_d;
    logic                   rd_ptr_q, rd_ptr_d;
    logic [1:0]             occ_q, occ_d;

    logic [LOG2N-1:0]       cnt_rev;
    logic [1:0]             occ_eff;
    logic                   issue;
    logic                   push;
    logic                   pop;

    // Bit-reverse the load counter to form the write address.
    always_comb begin
        cnt_rev = '0;
        for (int i = 0; i < int'(LOG2N); i++) begin
            cnt_rev[i] = cnt_q[int'(LOG2N) - 1 - i];
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q    <= StLoad;
            cnt_q      <= '0;
            rd_cnt_q   <= '0;
            out_cnt_q  <= '0;
            armed_q    <= 1'b0;
            rdy_q      <= 1'b0;
            inflight_q <= 1'b0;
            fifo_q[0]  <= '0;
            fifo_q[1]  <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            occ_q      <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rd_cnt_q   <= rd_cnt_d;
            out_cnt_q  <= out_cnt_d;
            armed_q    <= armed_d;
            rdy_q      <= rdy_d;
            inflight_q <= inflight_d;
            fifo_q[0]  <= fifo_d[0];
            fifo_q[1]  <= fifo_d[1];
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
        end
    end

    // Next-state logic, memory port control and output FIFO bookkeeping.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rd_cnt_d   = rd_cnt_q;
        out_cnt_d  = out_cnt_q;
        armed_d    = armed_q;
        rdy_d      = 1'b1;
        inflight_d = inflight_q;
        fifo_d     = fifo_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        occ_d      = occ_q;

        in_ready   = 1'b0;
        mem_own    = 1'b1;
        mem_addr   = '0;
        mem_wdata  = {in_re, in_im};
        mem_we     = 1'b0;
        start_fft  = 1'b0;
        out_valid  = (occ_q != 2'd0);
        push       = inflight_q;
        pop        = out_valid & out_ready;
        // Occupancy after this cycle's pop and push; a read issued now lands next cycle.
        occ_eff    = occ_q - {1'b0, pop} + {1'b0, inflight_q};
        issue      = 1'b0;

        unique case (state_q)
            StLoad: begin
                in_ready = rdy_q;
                mem_addr = cnt_rev;
                if (in_valid && rdy_q) begin
                    mem_we = 1'b1;
                    cnt_d  = cnt_q + LOG2N'(1);
                    if (cnt_q == LastIdx) begin
                        state_d = StStart;
                    end
                end
            end
            StStart: begin
                mem_own   = 1'b0;
                start_fft = 1'b1;
                armed_d   = 1'b0;
                state_d   = StWait;
            end
            StWait: begin
                mem_own   = 1'b0;
                start_fft = 1'b1;
                // A done level seen before it has been low once is stale.
                if (!fft_done) begin
                    armed_d = 1'b1;
                end else if (armed_q) begin
                    state_d = StUnload;
                end
            end
            StUnload: begin
                mem_addr   = rd_cnt_q[LOG2N-1:0];
                issue      = !rd_cnt_q[LOG2N] && (occ_eff < 2'd2);
                inflight_d = issue;
                if (issue) begin
                    rd_cnt_d = rd_cnt_q + (LOG2N + 1)'(1);
                end
                if (push) begin
                    fifo_d[wr_ptr_q] = mem_rdata;
                    wr_ptr_d         = ~wr_ptr_q;
                end
                if (pop) begin
                    rd_ptr_d  = ~rd_ptr_q;
                    out_cnt_d = out_cnt_q + (LOG2N + 1)'(1);
                end
                occ_d = occ_q + {1'b0, push} - {1'b0, pop};
                if (pop && out_cnt_q == LastOut) begin
                    state_d    = StLoad;
                    cnt_d      = '0;
                    rd_cnt_d   = '0;
                    out_cnt_d  = '0;
                    inflight_d = 1'b0;
                    wr_ptr_d   = 1'b0;
                    rd_ptr_d   = 1'b0;
                    occ_d      = '0;
                end
            end
            default: state_d = StLoad;
        endcase
    end

    assign out_re = fifo_q[rd_ptr_q][2*DATA_W-1:DATA_W];
    assign out_im = fifo_q[rd_ptr_q][DATA_W-1:0];
    assign busy   = !((state_q == StLoad) && (cnt_q == '0));

endmodule
